// File: rtl/program_loader.sv
// Byte-stream program loader: receives a length byte then N instruction words, writes them
// to instruction memory and releases the CPU. Optional trailing checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              load,
    output logic              is_instruction,
    output logic [ADDR_W-1:0] load_address,
    output logic [DATA_W-1:0] cpu_input,
    output logic              cpu_run,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [DATA_W:0] DEPTH_EXT = (DATA_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_LOAD  = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic              xfer_p0;
    logic [DATA_W:0]   len_ext;
    logic              len_ok;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   wc_inc;
    logic              last_byte;
    logic [ADDR_W-1:0] addr_cnt;

    assign xfer_p0   = in_valid && in_ready;
    assign len_ext   = {1'b0, in_data};
    assign len_ok    = (len_ext != '0) && (len_ext <= DEPTH_EXT);
    assign wc_inc    = word_count + (ADDR_W+1)'(1);
    assign last_byte = (wc_inc == len_r);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum_acc;
    logic       csum_ok;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign csum_ok = (in_data[7:0] == csum_acc);
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters in IDLE, RUN and ERR
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LEN;
            S_LEN: begin
                if (xfer_p0) state_nxt = len_ok ? S_LOAD : S_ERR;
            end
            S_LOAD: begin
                if (xfer_p0 && last_byte) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer_p0) state_nxt = csum_ok ? S_RUN : S_ERR;
            end
`endif
            S_RUN:  if (start) state_nxt = S_LEN;
            S_ERR:  if (start) state_nxt = S_LEN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        error    = 1'b0;
        cpu_run  = 1'b0;
        case (state)
            S_LEN, S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            S_RUN:   cpu_run = 1'b1;
            S_ERR:   error   = 1'b1;
            default: ;
        endcase
    end

    // Write pulse stage: memory sees the byte one cycle after its transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load           <= 1'b0;
            is_instruction <= 1'b0;
            load_address   <= '0;
            cpu_input      <= '0;
            addr_cnt       <= '0;
            word_count     <= '0;
            len_r          <= '0;
        end else begin
            load           <= 1'b0;
            is_instruction <= 1'b0;
            if (state == S_LEN && xfer_p0 && len_ok) begin
                addr_cnt   <= '0;
                word_count <= '0;
                len_r      <= len_ext[ADDR_W:0];
            end
            if (state == S_LOAD && xfer_p0) begin
                load           <= 1'b1;
                is_instruction <= 1'b1;
                load_address   <= addr_cnt;
                cpu_input      <= in_data;
                addr_cnt       <= addr_cnt + ADDR_W'(1);
                word_count     <= wc_inc;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_acc <= '0;
        end else if (state == S_LEN && xfer_p0 && len_ok) begin
            csum_acc <= '0;
        end else if (state == S_LOAD && xfer_p0) begin
            csum_acc <= csum_add(csum_acc, in_data[7:0]);
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader; follows PROGRAM_LOADER_CHECKSUM_EN if defined.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       load;
    logic       is_instruction;
    logic [4:0] load_address;
    logic [7:0] cpu_input;
    logic       cpu_run;
    logic       busy;
    logic       error;
    logic [5:0] word_count;

    int nvec = 0;
    int nbad = 0;

    program_loader #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .load(load), .is_instruction(is_instruction),
        .load_address(load_address), .cpu_input(cpu_input), .cpu_run(cpu_run),
        .busy(busy), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic [24:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [24:0] ex(input logic ir, input logic ld, input logic [4:0] a,
                                       input logic [7:0] dd, input logic run, input logic b,
                                       input logic e, input logic [5:0] wc);
        return {ir, ld, ld, a, dd, run, b, e, wc};
    endfunction

    function automatic logic [24:0] outs();
        return {in_ready, load, is_instruction, load_address, cpu_input, cpu_run, busy, error, word_count};
    endfunction

    task automatic add(input logic st, input logic v, input logic [7:0] d,
                       input logic [24:0] e, input string n);
        vec_t x;
        x.st = st; x.v = v; x.d = d; x.exp = e; x.name = n;
        tbl.push_back(x);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic v, input logic [7:0] d);
        start = st; in_valid = v; in_data = d;
        step();
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic do_reset();
        start = 0; in_valid = 0; in_data = 0;
        reset = 1'b1;
        #1;
        chk("reset_outs", {7'd0, outs()}, 32'd0);
        step();
        reset = 1'b0;
        step();
    endtask

    logic [7:0] sum;
    int         writes;
    int         order_ok;

    initial begin
        reset = 1'b0; start = 0; in_valid = 0; in_data = 0;
        #2;
        do_reset();
        chk("idle_after_reset", {7'd0, outs()}, 32'd0);

        // Basic load, ignored bytes/starts, bad lengths
        add(1, 0, 8'h00, ex(1, 0, 0, 8'h00, 0, 1, 0, 0), "start_len");
        add(0, 1, 8'h03, ex(1, 0, 0, 8'h00, 0, 1, 0, 0), "len3");
        add(0, 1, 8'hA1, ex(1, 1, 0, 8'hA1, 0, 1, 0, 1), "byteA1");
        add(0, 1, 8'hB2, ex(1, 1, 1, 8'hB2, 0, 1, 0, 2), "byteB2");
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        add(0, 1, 8'hC3, ex(1, 1, 2, 8'hC3, 0, 1, 0, 3), "byteC3");
        add(0, 1, 8'h16, ex(0, 0, 2, 8'hC3, 1, 0, 0, 3), "csum16");
`else
        add(0, 1, 8'hC3, ex(0, 1, 2, 8'hC3, 1, 0, 0, 3), "byteC3");
`endif
        add(0, 0, 8'h00, ex(0, 0, 2, 8'hC3, 1, 0, 0, 3), "run_hold");
        add(0, 1, 8'hFF, ex(0, 0, 2, 8'hC3, 1, 0, 0, 3), "run_ignore_byte");
        add(1, 0, 8'h00, ex(1, 0, 2, 8'hC3, 0, 1, 0, 3), "run_restart");
        add(0, 1, 8'h00, ex(0, 0, 2, 8'hC3, 0, 0, 1, 3), "len0_err");
        add(1, 0, 8'h00, ex(1, 0, 2, 8'hC3, 0, 1, 0, 3), "err_clear");
        add(0, 1, 8'h21, ex(0, 0, 2, 8'hC3, 0, 0, 1, 3), "len33_err");
        add(1, 1, 8'h55, ex(1, 0, 2, 8'hC3, 0, 1, 0, 3), "err_start_byte_ignored");
        add(0, 1, 8'h02, ex(1, 0, 2, 8'hC3, 0, 1, 0, 0), "len2");
        add(1, 1, 8'h10, ex(1, 1, 0, 8'h10, 0, 1, 0, 1), "load_start_ignored");
        add(0, 0, 8'h00, ex(1, 0, 0, 8'h10, 0, 1, 0, 1), "stall");
        add(1, 0, 8'h00, ex(1, 0, 0, 8'h10, 0, 1, 0, 1), "stall_start");
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        add(0, 1, 8'h20, ex(1, 1, 1, 8'h20, 0, 1, 0, 2), "byte20");
        add(0, 1, 8'h30, ex(0, 0, 1, 8'h20, 1, 0, 0, 2), "csum30");
`else
        add(0, 1, 8'h20, ex(0, 1, 1, 8'h20, 1, 0, 0, 2), "byte20");
`endif
        add(1, 0, 8'h00, ex(1, 0, 1, 8'h20, 0, 1, 0, 2), "run_restart2");

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].d);
            chk(tbl[i].name, {7'd0, outs()}, {7'd0, tbl[i].exp});
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum
        drive(0, 1, 8'h02);
        drive(0, 1, 8'h10);
        drive(0, 1, 8'h20);
        drive(0, 1, 8'h31);
        chk("csum_bad_err", {30'd0, error, cpu_run}, 32'd2);
`endif

        // Full-depth load with in_valid toggling
        do_reset();
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h20);
        chk("len32_wc", {26'd0, word_count}, 32'd0);
        sum = 8'h00; writes = 0; order_ok = 1;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b;
            b = 8'h80 + 8'(i * 3);
            sum = sum + b;
            drive(0, 1, b);
            if (load) begin
                writes++;
                if (load_address != 5'(i) || cpu_input != b) order_ok = 0;
            end
            drive(0, 0, 8'h00);
            if (load) writes++;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        drive(0, 1, sum);
        if (load) writes++;
`endif
        chk("full_writes", writes, 32'd32);
        chk("full_order", order_ok, 32'd1);
        chk("full_wc", {26'd0, word_count}, 32'd32);
        chk("full_run", {31'd0, cpu_run}, 32'd1);
        chk("full_last_addr", {27'd0, load_address}, 32'd31);

        // Asynchronous reset mid-load
        drive(1, 0, 8'h00);
        drive(0, 1, 8'h05);
        drive(0, 1, 8'h11);
        drive(0, 1, 8'h22);
        chk("pre_abort_load", {31'd0, load}, 32'd1);
        in_valid = 1'b1; in_data = 8'h33;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outs", {7'd0, outs()}, 32'd0);
        writes = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (load) writes++;
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (load) writes++;
        end
        in_valid = 1'b0;
        chk("abort_no_writes", writes, 32'd0);
        chk("abort_idle", {7'd0, outs()}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
